uart_rx_fifo: RTL and testbench

- Synthesizable UART receiver (8N1) with a first-word-fall-through receive FIFO, in the Ibex SoC peripheral domain.
- Consumes the serial stream that the SoC UART TX drives onto mprj_io[21].
- Used in loopback or self-check configurations and as the hardware counterpart of the bench's serial terminal.
- Presents received bytes on a valid/ready interface to the bus-side register block.

---
 rtl/uart_rx_fifo.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through receive FIFO.
// Sticky frame/overflow flags; a receiver disable drops any frame in flight.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          rx_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          clr_err_i
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // sync_reg[1] is the synchronized line, sync_reg[2] its one-cycle delay
  logic [2:0] sync_reg;
  logic       rxs;
  logic       rxs_d;

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             push;
  logic             ferr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] count_reg, count_next;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          ovf_set;
  logic          frame_err_reg;
  logic          overflow_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], rx_i};
    end
  end

  assign rxs   = sync_reg[1];
  assign rxs_d = sync_reg[2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    ferr_set   = 1'b0;
    if (!en_i) begin
      state_next = IDLE;
      cnt_next   = '0;
      bit_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // only a fresh high-to-low edge arms the receiver, so a held break is ignored
          if (rxs_d && !rxs) begin
            cnt_next   = '0;
            state_next = START;
          end
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_next = '0;
            if (!rxs) begin
              bit_next   = '0;
              state_next = DATA;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_next            = '0;
            shift_next[bit_reg] = rxs;
            if (bit_reg == 3'd7) begin
              state_next = STOP;
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_reg == FULL_LAST) begin
            cnt_next   = '0;
            state_next = IDLE;
            if (rxs) begin
              push = 1'b1;
            end else begin
              ferr_set = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign pop  = (count_reg != '0) && rx_ready_i;
  assign full = (count_reg == LW'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_comb begin
    count_next = count_reg;
    if (do_push && !pop) begin
      count_next = count_reg + LW'(1);
    end else if (!do_push && pop) begin
      count_next = count_reg - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg     <= count_next;
      frame_err_reg <= ferr_set | (frame_err_reg & ~clr_err_i);
      overflow_reg  <= ovf_set | (overflow_reg & ~clr_err_i);
    end
  end

  // head is forced to zero while empty so the output is clean out of reset
  assign rx_valid_o   = (count_reg != '0);
  assign rx_data_o    = rx_valid_o ? mem[rd_ptr_reg] : 8'h00;
  assign fifo_level_o = count_reg;
  assign frame_err_o  = frame_err_reg;
  assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames in, bytes compared against a queue model
// that decides acceptance, drops and errors from occupancy and stop-bit value.
module tb_uart_rx_fifo;
  localparam int CLKS  = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic [3:0] level;
  logic       ferr;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic [7:0] exp_q[$];
  logic       model_ferr;
  logic       model_ovf;

  uart_rx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .rx_i(rx),
    .rx_data_o(data), .rx_valid_o(valid), .rx_ready_i(ready),
    .fifo_level_o(level), .frame_err_o(ferr), .overflow_o(ovf), .clr_err_i(clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inputs are stable at the falling edge, so this is exactly the set of pops
  always @(negedge clk) begin
    if (valid && ready) begin
      got_q.push_back(data);
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start);
    rx = 1'b0;
    start = cyc;
    tick(CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CLKS);
    end
    rx = stop_bit;
    tick(CLKS);
    rx = 1'b1;
    tick(2);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit) model_ferr = 1'b1;
    else if (exp_q.size() - got_q.size() < DEPTH) exp_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic clear_model();
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    model_ferr = 1'b0;
    model_ovf = 1'b0;
  endtask

  task automatic compare_stream(input string tag);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL %s count: got %0d bytes, expected %0d", tag, got_q.size(), exp_q.size());
      n_err++;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        $display("FAIL %s byte%0d: got %h, expected %h", tag, i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        n_err++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (valid !== 1'b0) begin $display("FAIL reset_valid: got %b, expected 0", valid); n_err++; end
    n_vec++; if (data !== 8'h00) begin $display("FAIL reset_data: got %h, expected 00", data); n_err++; end
    n_vec++; if (level !== 4'd0) begin $display("FAIL reset_level: got %0d, expected 0", level); n_err++; end
    n_vec++; if (ferr !== 1'b0) begin $display("FAIL reset_ferr: got %b, expected 0", ferr); n_err++; end
    n_vec++; if (ovf !== 1'b0) begin $display("FAIL reset_ovf: got %b, expected 0", ovf); n_err++; end
    tick(3);
    rst_n = 1'b1;
    tick(3);
    clear_model();
  endtask

  task automatic test_basic();
    int s0, s1, lat;
    clear_model();
    ready = 1'b1;
    send_frame(8'h55, 1'b1, s0); model_frame(8'h55, 1'b1);
    tick(5);
    send_frame(8'hA4, 1'b1, s1); model_frame(8'hA4, 1'b1);
    tick(5);
    compare_stream("basic");
    for (int i = 0; i < 2; i++) begin
      lat = (i < got_cyc_q.size()) ? got_cyc_q[i] - ((i == 0) ? s0 : s1) : -1;
      n_vec++;
      if (lat < 152 || lat > 156) begin
        $display("FAIL basic_latency%0d: got %0d cycles, expected 152..156", i, lat);
        n_err++;
      end
    end
    n_vec++; if (ferr !== 1'b0) begin $display("FAIL basic_ferr: got %b, expected 0", ferr); n_err++; end
  endtask

  task automatic test_glitch();
    clear_model();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    n_vec++; if (level !== 4'd0 || got_q.size() != 0) begin $display("FAIL glitch_level: got %0d/%0d, expected 0/0", level, got_q.size()); n_err++; end
    n_vec++; if ({ferr, ovf} !== 2'b00) begin $display("FAIL glitch_flags: got %b%b, expected 00", ferr, ovf); n_err++; end
  endtask

  task automatic test_frame_err();
    int s;
    clear_model();
    ready = 1'b1;
    send_frame(8'hA4, 1'b0, s); model_frame(8'hA4, 1'b0);
    tick(3);
    n_vec++; if (ferr !== model_ferr) begin $display("FAIL ferr_set: got %b, expected %b", ferr, model_ferr); n_err++; end
    n_vec++; if (level !== 4'd0) begin $display("FAIL ferr_level: got %0d, expected 0", level); n_err++; end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_vec++; if (ferr !== 1'b0) begin $display("FAIL ferr_clear: got %b, expected 0", ferr); n_err++; end
    model_ferr = 1'b0;
    send_frame(8'h3C, 1'b1, s); model_frame(8'h3C, 1'b1);
    tick(3);
    compare_stream("after_ferr");
  endtask

  task automatic test_overflow();
    int s;
    clear_model();
    ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      send_frame(8'(b), 1'b1, s);
      model_frame(8'(b), 1'b1);
    end
    n_vec++; if (level !== 4'(exp_q.size())) begin $display("FAIL ovf_level: got %0d, expected %0d", level, exp_q.size()); n_err++; end
    n_vec++; if (ovf !== model_ovf) begin $display("FAIL ovf_flag: got %b, expected %b", ovf, model_ovf); n_err++; end
    n_vec++; if (data !== exp_q[0]) begin $display("FAIL ovf_head: got %h, expected %h", data, exp_q[0]); n_err++; end
    ready = 1'b1;
    tick(12);
    ready = 1'b0;
    compare_stream("drain");
    n_vec++; if (level !== 4'd0) begin $display("FAIL drain_level: got %0d, expected 0", level); n_err++; end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_vec++; if (ovf !== 1'b0) begin $display("FAIL ovf_clear: got %b, expected 0", ovf); n_err++; end
  endtask

  task automatic test_full_push_pop();
    int s;
    logic [7:0] b;
    clear_model();
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, s);
      model_frame(b, 1'b1);
    end
    n_vec++; if (level !== 4'd8) begin $display("FAIL full_level: got %0d, expected 8", level); n_err++; end
    // pop exactly at the push edge (stop sample lands 155 cycles after the start)
    fork
      send_frame(8'h0A, 1'b1, s);
      begin
        tick(154);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    exp_q.push_back(8'h0A);
    n_vec++; if (level !== 4'd8) begin $display("FAIL pushpop_level: got %0d, expected 8", level); n_err++; end
    n_vec++; if (ovf !== 1'b0) begin $display("FAIL pushpop_ovf: got %b, expected 0", ovf); n_err++; end
    ready = 1'b1;
    tick(12);
    compare_stream("pushpop");
  endtask

  task automatic test_enable();
    int s;
    logic [7:0] b;
    clear_model();
    ready = 1'b1;
    fork
      send_frame(8'($urandom), 1'b1, s);
      begin
        tick(50);
        en = 1'b0;
      end
    join
    tick(3);
    en = 1'b1;
    tick(5);
    n_vec++; if (got_q.size() != 0 || level !== 4'd0) begin $display("FAIL en_abort: got %0d bytes level %0d, expected 0", got_q.size(), level); n_err++; end
    n_vec++; if (ferr !== 1'b0) begin $display("FAIL en_ferr: got %b, expected 0", ferr); n_err++; end
    b = 8'($urandom);
    send_frame(b, 1'b1, s); model_frame(b, 1'b1);
    tick(3);
    compare_stream("after_en");
  endtask

  task automatic test_reset_mid();
    int s;
    clear_model();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, s);
    n_vec++; if (level !== 4'd1) begin $display("FAIL pre_reset_level: got %0d, expected 1", level); n_err++; end
    rx = 1'b0; tick(CLKS);
    rx = 1'b0; tick(CLKS);
    rx = 1'b1; tick(CLKS);
    rst_n = 1'b0;
    #1;
    n_vec++; if ({valid, level, data, ferr, ovf} !== 15'd0) begin
      $display("FAIL midreset_outputs: got valid=%b level=%0d data=%h ferr=%b ovf=%b, expected all 0", valid, level, data, ferr, ovf);
      n_err++;
    end
    tick(3);
    rst_n = 1'b1;
    tick(20);
    clear_model();
    ready = 1'b1;
    send_frame(8'h7E, 1'b1, s); model_frame(8'h7E, 1'b1);
    tick(3);
    compare_stream("after_reset");
  endtask

  task automatic test_random();
    int s;
    logic [7:0] b;
    logic stop_bit;
    clear_model();
    ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      stop_bit = ($urandom_range(0, 4) != 0);
      send_frame(b, stop_bit, s);
      model_frame(b, stop_bit);
      tick($urandom_range(1, 20));
    end
    compare_stream("random");
    n_vec++; if (ferr !== model_ferr) begin $display("FAIL random_ferr: got %b, expected %b", ferr, model_ferr); n_err++; end
    n_vec++; if (ovf !== model_ovf) begin $display("FAIL random_ovf: got %b, expected %b", ovf, model_ovf); n_err++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_full_push_pop();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
